uart_axi_arbiter: RTL and testbench
===================================

Name: uart_axi_arbiter

Overview:
- Two-requester AXI-lite master front-end for the UART peripheral slave at 0x2000_0000.
- Requester 0 is the core load/store path. Requester 1 is the debug/boot loader.
- Round-robin grant; one outstanding transaction at a time.
- Converts a simple req/ack interface into the slave's handshake: AW+W presented together, B and R returned only while BREADY/RREADY are held. Bounds every transaction with a timeout so a stalled slave cannot hang a requester.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles from grant to response before an error ack (≥2).
- N_REQ, 2, number of requesters (fixed at 2 in this revision).

Ports:
- s_axi_aclk_i  in  1  clock
- s_axi_aresetn_i  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed)
- req_i  in  2  per-requester request level; held until ack
- we_i  in  2  per-requester 1=write, 0=read
- addr_i  in  64  {addr1,addr0}, 32b each
- wdata_i  in  64  {wdata1,wdata0}
- ack_o  out  2  one-cycle completion pulse to the granted requester
- err_o  out  1  valid with ack_o; 1=timeout
- rdata_o  out  32  read data, valid with ack_o on a read
- m_axi_awaddr_o  out  32  slave write address
- m_axi_awvalid_o  out  1  slave write address valid
- m_axi_awready_i  in  1  slave write address ready
- m_axi_wdata_o  out  32  slave write data
- m_axi_wvalid_o  out  1  slave write data valid
- m_axi_wready_i  in  1  slave write data ready
- m_axi_bvalid_i  in  1  slave write response valid
- m_axi_bready_o  out  1  slave write response ready
- m_axi_araddr_o  out  32  slave read address
- m_axi_arvalid_o  out  1  slave read address valid
- m_axi_arready_i  in  1  slave read address ready
- m_axi_rdata_i  in  32  slave read data
- m_axi_rvalid_i  in  1  slave read data valid
- m_axi_rready_o  out  1  slave read data ready

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so requester 0 wins first; timeout counter 0.
- State IDLE:
  - If any req_i, pick the winner: the requester other than last_grant if it requests, else the only requester.
  - Latch we, addr and wdata of the winner; set last_grant=winner; go to ADDR.
  - The grant decision is made in the same cycle as req is seen; AXI valids assert the next cycle.
- State ADDR (write):
  - awvalid=wvalid=1, bready=1.
  - When awready&wready are both seen (the slave raises them together), drop awvalid/wvalid next cycle and go to RESP.
- State ADDR (read):
  - arvalid=1, rready=1.
  - On arready, drop arvalid and go to RESP.
- State RESP:
  - bready (write) or rready (read) stays 1.
  - On bvalid or rvalid, capture rdata (reads only), go to DONE.
  - A response arriving in the same cycle as ready is accepted.
- State DONE:
  - ack_o[winner]=1 for exactly one cycle, err_o=0; all AXI outputs 0.
  - Next state IDLE.
  - Requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request.
- Minimum transaction length: IDLE→ADDR→RESP→DONE, so ack appears ≥3 cycles after req is sampled.
- bvalid/rvalid seen in IDLE, ADDR or DONE: ignored; no stale data reaches rdata_o.
- Latched addr/wdata are stable for the whole transaction. Requester-side changes while granted are ignored.
- Reset mid-transaction: all outputs drop to 0 the next cycle; the pending requester gets no ack and must reissue.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - The counter counts every cycle in ADDR or RESP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the arbiter goes to DONE with err_o=1 and rdata_o=0, and all valids/readies drop.
  - This covers an unmapped address with no ready, a read of rdata while RX is empty, and a slave that never responds.
- UART_ARB_TIMEOUT_EN undefined:
  - No counter; the arbiter waits indefinitely.
  - err_o is tied to 0.

Decomposition:
- Package uart_arb_pkg:
  - State enum codes: IDLE=2'd0, ADDR=2'd1, RESP=2'd2, DONE=2'd3.
  - UART_BASE_ADDR=32'h2000_0000.
  - Default TIMEOUT_CYCLES.
- Sub-module rr_arbiter_2: a pure grant picker with inputs req[1:0], last_grant and output grant-index.
- The FSM and AXI drive remain in the top module.

Test Plan:
- req_i=01, we=1, addr0=0x2000_0000, wdata0=0x0001_0003; slave readies after 2 cycles and bvalid 1 cycle later → one write on the bus, ack_o=01, err_o=0.
- req_i=10, we=0, addr1=0x2000_0004; rvalid with rdata=0x0000_000A → rdata_o=0x0000_000A with ack_o=10.
- req_i=11 held for three back-to-back transactions → grants in the order 0,1,0; acks never overlap.
- With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: read of 0x2000_0008 where the slave gives arready but never rvalid → ack with err_o=1 and rdata_o=0 exactly 8 cycles after ADDR entry. Without the macro → no ack after 100 cycles.
- Reset asserted while in RESP → the next cycle all AXI outputs and ack_o are 0 and the state is IDLE; a late rvalid is ignored.
- Spurious bvalid pulse in IDLE → no ack, rdata_o unchanged.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared constants and types for the two-requester AXI-lite
//                front-end of the UART peripheral slave.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    // Transaction FSM codes (2-bit encoding kept for legacy compatibility)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Base address of the UART slave on the AXI-lite bus
    localparam logic [31:0] UART_BASE_ADDR = 32'h2000_0000;

    // Default bound from grant to response
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Request captured from the winning requester at grant time
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Two-way round-robin grant picker. Purely combinational:
//                favours the requester that did not win last time, falls back
//                to the other one. Output is only meaningful when any request
//                bit is set.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant
);

    logic w_other;

    // Prefer the requester that lost the previous round if it is asking
    always_comb begin
        w_other = ~i_last_grant;
        o_grant = i_req[w_other] ? w_other : i_last_grant;
    end

endmodule
`default_nettype wire

// File: rtl/uart_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_axi_arbiter
//  Description : Round-robin AXI-lite master front-end for the UART slave.
//                Two req/ack requesters share one outstanding transaction.
//                Write: AW+W presented together, then B. Read: AR, then R.
//  Config macro: UART_ARB_TIMEOUT_EN - when defined, a transaction that has
//                spent TIMEOUT_CYCLES in ADDR/RESP is completed with err_o=1.
//                When undefined the arbiter waits forever and err_o is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_axi_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int N_REQ          = 2
) (
    input  logic                 s_axi_aclk_i,
    input  logic                 s_axi_aresetn_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ-1:0]     we_i,
    input  logic [32*N_REQ-1:0]  addr_i,
    input  logic [32*N_REQ-1:0]  wdata_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic                 err_o,
    output logic [31:0]          rdata_o,
    output logic [31:0]          m_axi_awaddr_o,
    output logic                 m_axi_awvalid_o,
    input  logic                 m_axi_awready_i,
    output logic [31:0]          m_axi_wdata_o,
    output logic                 m_axi_wvalid_o,
    input  logic                 m_axi_wready_i,
    input  logic                 m_axi_bvalid_i,
    output logic                 m_axi_bready_o,
    output logic [31:0]          m_axi_araddr_o,
    output logic                 m_axi_arvalid_o,
    input  logic                 m_axi_arready_i,
    input  logic [31:0]          m_axi_rdata_i,
    input  logic                 m_axi_rvalid_i,
    output logic                 m_axi_rready_o
);

    // Elaboration guards on the configuration
    if (N_REQ != 2) begin : g_bad_n_req
        $error("uart_axi_arbiter supports exactly two requesters");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_axi_arbiter TIMEOUT_CYCLES must be at least 2");
    end

    logic [1:0]  r_state;
    txn_t        r_txn;
    logic        r_winner;
    logic        r_last_grant;
    logic [31:0] r_rdata;

    logic        w_grant;
    logic        w_active;
    logic        w_addr_done;
    logic        w_resp;
    logic        w_timeout;
    logic        w_err;

    rr_arbiter_2 u_rr (
        .i_req        (req_i),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Handshake qualifiers for the latched transaction direction
    always_comb begin
        w_active    = (r_state == ADDR) || (r_state == RESP);
        w_addr_done = r_txn.we ? (m_axi_awready_i & m_axi_wready_i) : m_axi_arready_i;
        w_resp      = r_txn.we ? m_axi_bvalid_i : m_axi_rvalid_i;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    always_comb begin
        w_timeout = w_active && (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
        w_err     = (r_state == DONE) && r_err;
    end

    // Cycle budget for the granted transaction; remembers whether it expired
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_aresetn_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_active) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            // A real response accepted in the last cycle still wins
            r_err <= w_timeout && !((r_state == RESP) && w_resp);
        end
    end
`else
    always_comb begin
        w_timeout = 1'b0;
        w_err     = 1'b0;
    end
`endif

    // Transaction FSM: grant, address phase, response phase, one-cycle ack
    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_aresetn_i) begin
            r_state      <= IDLE;
            r_txn        <= '0;
            r_winner     <= 1'b0;
            r_last_grant <= 1'b1;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_i) begin
                        r_winner     <= w_grant;
                        r_last_grant <= w_grant;
                        r_txn.we     <= we_i[w_grant];
                        r_txn.addr   <= w_grant ? addr_i[63:32]  : addr_i[31:0];
                        r_txn.wdata  <= w_grant ? wdata_i[63:32] : wdata_i[31:0];
                        r_state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_timeout) begin
                        r_rdata <= '0;
                        r_state <= DONE;
                    end else if (w_addr_done) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (w_resp) begin
                        if (!r_txn.we) begin
                            r_rdata <= m_axi_rdata_i;
                        end
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // AXI and requester-side outputs decoded from state; zero outside activity
    always_comb begin
        m_axi_awvalid_o = (r_state == ADDR) && r_txn.we;
        m_axi_wvalid_o  = (r_state == ADDR) && r_txn.we;
        m_axi_bready_o  = w_active && r_txn.we;
        m_axi_arvalid_o = (r_state == ADDR) && !r_txn.we;
        m_axi_rready_o  = w_active && !r_txn.we;
        m_axi_awaddr_o  = (w_active && r_txn.we)  ? r_txn.addr  : 32'h0;
        m_axi_wdata_o   = (w_active && r_txn.we)  ? r_txn.wdata : 32'h0;
        m_axi_araddr_o  = (w_active && !r_txn.we) ? r_txn.addr  : 32'h0;
        ack_o           = '0;
        if (r_state == DONE) begin
            ack_o[r_winner] = 1'b1;
        end
        err_o           = w_err;
        rdata_o         = r_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_axi_arbiter
//  Description : Directed self-checking bench for uart_axi_arbiter with a
//                small configurable AXI-lite slave responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_axi_arbiter;
    import uart_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [1:0]  ack_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic [31:0] m_axi_awaddr_o;
    logic        m_axi_awvalid_o;
    logic        m_axi_awready_i;
    logic [31:0] m_axi_wdata_o;
    logic        m_axi_wvalid_o;
    logic        m_axi_wready_i;
    logic        m_axi_bvalid_i;
    logic        m_axi_bready_o;
    logic [31:0] m_axi_araddr_o;
    logic        m_axi_arvalid_o;
    logic        m_axi_arready_i;
    logic [31:0] m_axi_rdata_i;
    logic        m_axi_rvalid_i;
    logic        m_axi_rready_o;

    // Responder configuration and logs
    int          cfg_rdy_dly;
    int          cfg_rsp_dly;
    bit          cfg_no_resp;
    logic [31:0] cfg_rdata;
    bit          cfg_spur_b;
    bit          cfg_spur_r;
    logic [31:0] cfg_spur_data;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];
    int          n_overlap;

    int          n_chk;
    int          n_err;

    uart_axi_arbiter #(
        .TIMEOUT_CYCLES (8),
        .N_REQ          (2)
    ) dut (
        .s_axi_aclk_i    (clk),
        .s_axi_aresetn_i (rst),
        .req_i           (req_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .rdata_o         (rdata_o),
        .m_axi_awaddr_o  (m_axi_awaddr_o),
        .m_axi_awvalid_o (m_axi_awvalid_o),
        .m_axi_awready_i (m_axi_awready_i),
        .m_axi_wdata_o   (m_axi_wdata_o),
        .m_axi_wvalid_o  (m_axi_wvalid_o),
        .m_axi_wready_i  (m_axi_wready_i),
        .m_axi_bvalid_i  (m_axi_bvalid_i),
        .m_axi_bready_o  (m_axi_bready_o),
        .m_axi_araddr_o  (m_axi_araddr_o),
        .m_axi_arvalid_o (m_axi_arvalid_o),
        .m_axi_arready_i (m_axi_arready_i),
        .m_axi_rdata_i   (m_axi_rdata_i),
        .m_axi_rvalid_i  (m_axi_rvalid_i),
        .m_axi_rready_o  (m_axi_rready_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait on falling edges for an ack, bounded by limit; lat counts edges
    task automatic wait_ack(input int limit, output int lat, output logic [1:0] a,
                            output logic e, output logic [31:0] d);
        lat = 0;
        a   = 2'b00;
        e   = 1'b0;
        d   = 32'h0;
        while (lat < limit) begin
            @(negedge clk);
            lat++;
            if (ack_o != 2'b00) begin
                a = ack_o;
                e = err_o;
                d = rdata_o;
                break;
            end
        end
    endtask

    // AXI-lite slave model: drives on falling edges, DUT samples on rising
    initial begin
        int  wcnt, rcnt, bcnt, rrcnt;
        bit  bpend, rpend;
        wcnt = 0; rcnt = 0; bcnt = 0; rrcnt = 0; bpend = 0; rpend = 0;
        m_axi_awready_i = 1'b0;
        m_axi_wready_i  = 1'b0;
        m_axi_arready_i = 1'b0;
        m_axi_bvalid_i  = 1'b0;
        m_axi_rvalid_i  = 1'b0;
        m_axi_rdata_i   = 32'h0;
        forever begin
            @(negedge clk);
            m_axi_awready_i = 1'b0;
            m_axi_wready_i  = 1'b0;
            m_axi_arready_i = 1'b0;
            m_axi_bvalid_i  = 1'b0;
            m_axi_rvalid_i  = 1'b0;
            if (ack_o == 2'b11) n_overlap++;
            if (rst) begin
                wcnt = 0; rcnt = 0; bpend = 0; rpend = 0;
            end else begin
                if (m_axi_awvalid_o && m_axi_wvalid_o) begin
                    if (wcnt >= cfg_rdy_dly) begin
                        m_axi_awready_i = 1'b1;
                        m_axi_wready_i  = 1'b1;
                        wr_addr_q.push_back(m_axi_awaddr_o);
                        wr_data_q.push_back(m_axi_wdata_o);
                        wcnt  = 0;
                        bpend = !cfg_no_resp;
                        bcnt  = cfg_rsp_dly;
                    end else begin
                        wcnt++;
                    end
                end else if (bpend) begin
                    if (bcnt <= 1) begin
                        m_axi_bvalid_i = 1'b1;
                        bpend = 0;
                    end else begin
                        bcnt--;
                    end
                end
                if (m_axi_arvalid_o) begin
                    if (rcnt >= cfg_rdy_dly) begin
                        m_axi_arready_i = 1'b1;
                        rd_addr_q.push_back(m_axi_araddr_o);
                        rcnt  = 0;
                        rpend = !cfg_no_resp;
                        rrcnt = cfg_rsp_dly;
                    end else begin
                        rcnt++;
                    end
                end else if (rpend) begin
                    if (rrcnt <= 1) begin
                        m_axi_rvalid_i = 1'b1;
                        m_axi_rdata_i  = cfg_rdata;
                        rpend = 0;
                    end else begin
                        rrcnt--;
                    end
                end
                if (cfg_spur_b) begin
                    m_axi_bvalid_i = 1'b1;
                    cfg_spur_b = 0;
                end
                if (cfg_spur_r) begin
                    m_axi_rvalid_i = 1'b1;
                    m_axi_rdata_i  = cfg_spur_data;
                    cfg_spur_r = 0;
                end
            end
        end
    end

    initial begin
        int          lat;
        logic [1:0]  a;
        logic        e;
        logic [31:0] d;
        n_chk = 0; n_err = 0; n_overlap = 0;
        cfg_rdy_dly = 0; cfg_rsp_dly = 1; cfg_no_resp = 0;
        cfg_rdata = 32'h0; cfg_spur_b = 0; cfg_spur_r = 0; cfg_spur_data = 32'h0;
        req_i = 2'b00; we_i = 2'b00; addr_i = 64'h0; wdata_i = 64'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_bus", {59'h0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                            m_axi_arvalid_o, m_axi_rready_o}, 64'h0);
        check("reset_ack", {61'h0, ack_o, err_o}, 64'h0);
        check("reset_rdata", {32'h0, rdata_o}, 64'h0);
        check("reset_addr", {m_axi_awaddr_o, m_axi_araddr_o}, 64'h0);
        rst = 1'b0;

        // Write from requester 0, readies after 2 cycles, B one cycle later
        @(negedge clk);
        cfg_rdy_dly = 2; cfg_rsp_dly = 1;
        req_i = 2'b01; we_i = 2'b01;
        addr_i = {32'h0, UART_BASE_ADDR};
        wdata_i = {32'h0, 32'h0001_0003};
        @(negedge clk);
        addr_i = {32'h0, 32'hDEAD_BEEF};  // changes after grant must not leak
        wdata_i = {32'h0, 32'hCAFE_F00D};
        wait_ack(50, lat, a, e, d);
        req_i = 2'b00;
        check("wr_ack", {62'h0, a}, 64'h1);
        check("wr_err", {63'h0, e}, 64'h0);
        check("wr_lat", 64'(lat + 1), 64'd5);
        check("wr_count", 64'(wr_addr_q.size()), 64'd1);
        check("wr_addr", {32'h0, wr_addr_q[0]}, {32'h0, UART_BASE_ADDR});
        check("wr_data", {32'h0, wr_data_q[0]}, 64'h0001_0003);
        @(negedge clk);
        check("wr_ack_pulse", {62'h0, ack_o}, 64'h0);

        // Read from requester 1, zero-latency slave
        cfg_rdy_dly = 0; cfg_rdata = 32'h0000_000A;
        req_i = 2'b10; we_i = 2'b00;
        addr_i = {UART_BASE_ADDR + 32'h4, 32'h0};
        wait_ack(50, lat, a, e, d);
        req_i = 2'b00;
        check("rd_ack", {62'h0, a}, 64'h2);
        check("rd_err", {63'h0, e}, 64'h0);
        check("rd_data", {32'h0, d}, 64'h0000_000A);
        check("rd_lat", 64'(lat), 64'd3);
        check("rd_araddr", {32'h0, rd_addr_q[0]}, 64'h2000_0004);

        // Both requesting, three back-to-back writes: order 0,1,0
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        req_i = 2'b11; we_i = 2'b11;
        addr_i  = {32'h2000_0014, 32'h2000_0010};
        wdata_i = {32'h0000_0111, 32'h0000_0100};
        wait_ack(50, lat, a, e, d);
        check("rr_ack0", {62'h0, a}, 64'h1);
        wait_ack(50, lat, a, e, d);
        check("rr_ack1", {62'h0, a}, 64'h2);
        wait_ack(50, lat, a, e, d);
        check("rr_ack2", {62'h0, a}, 64'h1);
        req_i = 2'b00;
        check("rr_count", 64'(wr_addr_q.size()), 64'd3);
        check("rr_addr0", {32'h0, wr_addr_q[0]}, 64'h2000_0010);
        check("rr_addr1", {32'h0, wr_addr_q[1]}, 64'h2000_0014);
        check("rr_data1", {32'h0, wr_data_q[1]}, 64'h0000_0111);
        check("rr_addr2", {32'h0, wr_addr_q[2]}, 64'h2000_0010);
        check("rr_overlap", 64'(n_overlap), 64'd0);

        // Slave accepts AR but never returns R
        @(negedge clk);
        cfg_no_resp = 1;
        req_i = 2'b01; we_i = 2'b00;
        addr_i = {32'h0, UART_BASE_ADDR + 32'h8};
`ifdef UART_ARB_TIMEOUT_EN
        wait_ack(50, lat, a, e, d);
        req_i = 2'b00;
        check("to_ack", {62'h0, a}, 64'h1);
        check("to_err", {63'h0, e}, 64'h1);
        check("to_rdata", {32'h0, d}, 64'h0);
        check("to_lat", 64'(lat), 64'd9);
`else
        wait_ack(100, lat, a, e, d);
        req_i = 2'b00;
        check("noto_ack", {62'h0, a}, 64'h0);
        check("noto_err", {63'h0, err_o}, 64'h0);
`endif

        // Reset while waiting in RESP, then a late R must be ignored
        @(negedge clk);
        req_i = 2'b01; we_i = 2'b00;
        addr_i = {32'h0, UART_BASE_ADDR + 32'hC};
        repeat (2) @(negedge clk);
        check("rst_in_resp", {63'h0, m_axi_rready_o}, 64'h1);
        rst = 1'b1;
        req_i = 2'b00;
        @(negedge clk);
        check("rst_bus", {59'h0, m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
                          m_axi_arvalid_o, m_axi_rready_o}, 64'h0);
        check("rst_ack", {61'h0, ack_o, err_o}, 64'h0);
        check("rst_araddr", {32'h0, m_axi_araddr_o}, 64'h0);
        rst = 1'b0;
        cfg_no_resp = 0;
        cfg_spur_data = 32'h0000_DEAD;
        cfg_spur_r = 1;
        wait_ack(6, lat, a, e, d);
        check("late_r_ack", {62'h0, a}, 64'h0);
        check("late_r_rdata", {32'h0, rdata_o}, 64'h0);

        // Establish known read data, then spurious B and R while idle
        cfg_rdata = 32'h0000_0055;
        req_i = 2'b10; we_i = 2'b00;
        addr_i = {UART_BASE_ADDR, 32'h0};
        wait_ack(50, lat, a, e, d);
        req_i = 2'b00;
        check("rd2_ack", {62'h0, a}, 64'h2);
        check("rd2_data", {32'h0, d}, 64'h55);
        @(negedge clk);
        cfg_spur_b = 1;
        wait_ack(6, lat, a, e, d);
        check("spur_b_ack", {62'h0, a}, 64'h0);
        check("spur_b_rdata", {32'h0, rdata_o}, 64'h55);
        cfg_spur_data = 32'h0000_0077;
        cfg_spur_r = 1;
        wait_ack(6, lat, a, e, d);
        check("spur_r_ack", {62'h0, a}, 64'h0);
        check("spur_r_rdata", {32'h0, rdata_o}, 64'h55);
        check("overlap_final", 64'(n_overlap), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
